// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops words from a show-ahead FIFO read port and presents
// them as a registered valid/ready stream through a 2-entry buffer.
// The stream is framed into BURST_LEN-beat bursts with out_last and a
// burst_done pulse one cycle after the last beat handshakes.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int POP_GAP    = 1
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  burst_done
);
  // Gap counter needs at least one bit even when POP_GAP is 0.
  localparam int            GW        = (POP_GAP > 0) ? $clog2(POP_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LD    = GW'(POP_GAP);
  localparam logic [7:0]    LAST_BEAT = 8'(BURST_LEN - 1);

  // Entry 0 is always the head; entry 1 is only meaningful when cnt_q==2.
  logic [1:0][DATA_WIDTH-1:0] buf_q;
  logic [1:0]                 cnt_q;
  logic [7:0]                 beat_q;
  logic [GW-1:0]              gap_q;
  logic                       gap_ok;
  logic                       hs;
  logic                       pop;

  assign gap_ok     = (gap_q == '0);
  assign out_valid  = (cnt_q != 2'd0);
  assign out_data   = buf_q[0];
  assign out_last   = out_valid && (beat_q == LAST_BEAT);
  assign hs         = out_valid && out_ready;
  // A full buffer may only accept a word when the head leaves this cycle.
  assign pop        = !rst && en && !fifo_empty && gap_ok &&
                      ((cnt_q != 2'd2) || out_ready);
  assign fifo_rd_en = pop;

  // Buffer storage and occupancy: pop writes the tail, handshake shifts the head.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      unique case ({pop, hs})
        2'b10: begin
          if (cnt_q == 2'd0) buf_q[0] <= fifo_rd_data;
          else               buf_q[1] <= fifo_rd_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          buf_q[0] <= buf_q[1];
          cnt_q    <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Count stays put: head advances while the new word lands behind it.
          if (cnt_q == 2'd1) begin
            buf_q[0] <= fifo_rd_data;
          end else begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Burst framing: count handshakes, wrap on the last beat, pulse burst_done after it.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      beat_q     <= 8'd0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= hs && out_last;
      if (hs) beat_q <= (beat_q == LAST_BEAT) ? 8'd0 : beat_q + 8'd1;
    end
  end

  // Pop spacing: reload on every pop, count down to zero between pops.
  always_ff @(posedge rd_clk) begin
    if (rst)              gap_q <= '0;
    else if (pop)         gap_q <= GAP_LD;
    else if (gap_q != '0) gap_q <= gap_q - GW'(1);
  end
endmodule
